layer_priority_mux: RTL and testbench

Parametrised, pipelined successor to the fixed VGA objects multiplexer. It merges NUM_LAYERS sprite layers plus a background and a MIF fallback into one RGB pixel using fixed priority: layer 0 highest, then the background, then the MIF. It adds per-layer enable and blink masks, colour-key transparency, and per-frame collision flags against layer 0 (the player object). It sits between the object drawers and the VGA controller.

---
 rtl/layer_priority_mux.sv | 116 +++++++++++
 tb/tb_layer_priority_mux.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/layer_priority_mux.sv
// Pipelined sprite/background/MIF pixel merger with per-layer enable, blink and colour-key
// masking, plus per-frame collision flags of every layer against layer 0.
module layer_priority_mux #(
   parameter int                NUM_LAYERS  = 4,
   parameter int                RGB_W       = 8,
   parameter logic [RGB_W-1:0]  TRANSPARENT = 8'hFF,
   parameter int                BLINK_SHIFT = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_LAYERS-1:0]       layerDrawingRequest,
   input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
   input  logic [NUM_LAYERS-1:0]       layerEnable,
   input  logic [NUM_LAYERS-1:0]       blinkMask,
   input  logic                        BGDrawingRequest,
   input  logic [RGB_W-1:0]            backGroundRGB,
   input  logic [RGB_W-1:0]            RGB_MIF,
   input  logic                        startOfFrame,
   output logic [RGB_W-1:0]            RGBOut,
   output logic [4:0]                  topLayer,
   output logic [NUM_LAYERS-1:0]       collisionFlags,
   output logic                        collisionValid
);

   localparam logic [4:0] TOP_NONE = 5'd31;

   logic [7:0]                  frame_cnt_q, frame_cnt_d;
   logic                        blink_on;
   logic [NUM_LAYERS-1:0]       eff0;
   logic [NUM_LAYERS-1:0]       hits;

   logic [NUM_LAYERS-1:0]       eff1_q, eff1_d;
   logic [NUM_LAYERS*RGB_W-1:0] rgb1_q, rgb1_d;
   logic                        bg_req1_q, bg_req1_d;
   logic [RGB_W-1:0]            bg_rgb1_q, bg_rgb1_d;
   logic [RGB_W-1:0]            mif1_q, mif1_d;

   logic [RGB_W-1:0]            rgb_out_q, rgb_out_d;
   logic [4:0]                  top_q, top_d;
   logic [NUM_LAYERS-1:0]       hit_acc_q, hit_acc_d;
   logic [NUM_LAYERS-1:0]       flags_q, flags_d;
   logic                        valid_q, valid_d;

   always_comb begin
      eff0     = '0;
      blink_on = frame_cnt_q[BLINK_SHIFT];
      for (int i = 0; i < NUM_LAYERS; i++) begin
         eff0[i] = layerDrawingRequest[i] & layerEnable[i] & ~(blinkMask[i] & blink_on)
                 & (layerRGB[i*RGB_W +: RGB_W] != TRANSPARENT);
      end

      eff1_d    = eff0;
      rgb1_d    = layerRGB;
      bg_req1_d = BGDrawingRequest;
      bg_rgb1_d = backGroundRGB;
      mif1_d    = RGB_MIF;

      // Walk from lowest priority up so the lowest-index layer overwrites last.
      rgb_out_d = bg_req1_q ? bg_rgb1_q : mif1_q;
      top_d     = TOP_NONE;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (eff1_q[i]) begin
            rgb_out_d = rgb1_q[i*RGB_W +: RGB_W];
            top_d     = 5'(i);
         end
      end

      hits = eff1_q[0] ? {eff1_q[NUM_LAYERS-1:1], 1'b0} : '0;

      // The frame-boundary cycle still contributes its own hits to the closing snapshot.
      frame_cnt_d = frame_cnt_q;
      hit_acc_d   = hit_acc_q | hits;
      flags_d     = flags_q;
      valid_d     = 1'b0;
      if (startOfFrame) begin
         frame_cnt_d = frame_cnt_q + 8'd1;
         hit_acc_d   = '0;
         flags_d     = hit_acc_q | hits;
         valid_d     = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt_q <= '0;
         eff1_q      <= '0;
         rgb1_q      <= '0;
         bg_req1_q   <= 1'b0;
         bg_rgb1_q   <= '0;
         mif1_q      <= '0;
         rgb_out_q   <= '0;
         top_q       <= TOP_NONE;
         hit_acc_q   <= '0;
         flags_q     <= '0;
         valid_q     <= 1'b0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         eff1_q      <= eff1_d;
         rgb1_q      <= rgb1_d;
         bg_req1_q   <= bg_req1_d;
         bg_rgb1_q   <= bg_rgb1_d;
         mif1_q      <= mif1_d;
         rgb_out_q   <= rgb_out_d;
         top_q       <= top_d;
         hit_acc_q   <= hit_acc_d;
         flags_q     <= flags_d;
         valid_q     <= valid_d;
      end
   end

   assign RGBOut         = rgb_out_q;
   assign topLayer       = top_q;
   assign collisionFlags = flags_q;
   assign collisionValid = valid_q;

endmodule

// File: tb/tb_layer_priority_mux.sv
// Directed bench for layer_priority_mux: a scoreboard of expected pixels (due two cycles
// after drive) plus a frame/collision model, with explicit checks for the key scenarios.
module tb_layer_priority_mux;

   localparam int NL = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [NL-1:0] layerDrawingRequest = '0;
   logic [NL*8-1:0] layerRGB = '0;
   logic [NL-1:0] layerEnable = '1;
   logic [NL-1:0] blinkMask = '0;
   logic          BGDrawingRequest = 1'b0;
   logic [7:0]    backGroundRGB = 8'h55;
   logic [7:0]    RGB_MIF = 8'hA5;
   logic          startOfFrame = 1'b0;
   logic [7:0]    RGBOut;
   logic [4:0]    topLayer;
   logic [NL-1:0] collisionFlags;
   logic          collisionValid;

   layer_priority_mux #(.NUM_LAYERS(NL), .RGB_W(8), .TRANSPARENT(8'hFF), .BLINK_SHIFT(1)) dut (
      .clk(clk), .reset(reset),
      .layerDrawingRequest(layerDrawingRequest), .layerRGB(layerRGB),
      .layerEnable(layerEnable), .blinkMask(blinkMask),
      .BGDrawingRequest(BGDrawingRequest), .backGroundRGB(backGroundRGB),
      .RGB_MIF(RGB_MIF), .startOfFrame(startOfFrame),
      .RGBOut(RGBOut), .topLayer(topLayer),
      .collisionFlags(collisionFlags), .collisionValid(collisionValid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] rgb;
      logic [4:0] top;
      int         due;
   } exp_t;

   exp_t          sb[$];
   int            checks = 0;
   int            passes = 0;
   int            step_no = 0;
   logic [7:0]    m_fc = '0;
   logic [NL-1:0] m_eff1 = '0;
   logic [NL-1:0] m_acc = '0;
   logic [NL-1:0] m_flags = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic set_layer(input int i, input logic req, input logic [7:0] rgb);
      layerDrawingRequest[i] = req;
      layerRGB[i*8 +: 8]     = rgb;
   endtask

   task automatic clear_layers();
      layerDrawingRequest = '0;
      BGDrawingRequest    = 1'b0;
   endtask

   function automatic logic [NL-1:0] model_eff();
      logic [NL-1:0] e;
      e = '0;
      for (int i = 0; i < NL; i++)
         e[i] = layerDrawingRequest[i] & layerEnable[i] & ~(blinkMask[i] & m_fc[1])
              & (layerRGB[i*8 +: 8] != 8'hFF);
      return e;
   endfunction

   task automatic step(input logic sof);
      exp_t          e;
      logic [NL-1:0] eff, hit;
      startOfFrame = sof;
      eff   = model_eff();
      e.rgb = BGDrawingRequest ? backGroundRGB : RGB_MIF;
      e.top = 5'd31;
      for (int i = NL - 1; i >= 0; i--)
         if (eff[i]) begin
            e.rgb = layerRGB[i*8 +: 8];
            e.top = 5'(i);
         end
      e.due = step_no + 1;
      sb.push_back(e);
      hit = m_eff1[0] ? (m_eff1 & 4'b1110) : 4'b0000;
      @(posedge clk); #1;
      if (sof) begin
         m_flags = m_acc | hit;
         m_acc   = '0;
         m_fc    = m_fc + 8'd1;
      end else begin
         m_acc = m_acc | hit;
      end
      m_eff1 = eff;
      chk("coll_valid", collisionValid, sof);
      chk("coll_flags", collisionFlags, m_flags);
      if (sb.size() > 0 && sb[0].due == step_no) begin
         e = sb.pop_front();
         chk("rgb_out", RGBOut, e.rgb);
         chk("top_layer", topLayer, e.top);
      end
      startOfFrame = 1'b0;
      step_no++;
   endtask

   task automatic do_reset();
      exp_t e;
      startOfFrame = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst_rgb", RGBOut, 8'h00);
      chk("rst_top", topLayer, 5'd31);
      chk("rst_flags", collisionFlags, 4'b0000);
      chk("rst_valid", collisionValid, 1'b0);
      sb.delete();
      e.rgb = 8'h00;
      e.top = 5'd31;
      e.due = step_no;
      sb.push_back(e);
      m_fc = '0; m_eff1 = '0; m_acc = '0; m_flags = '0;
   endtask

   initial begin
      do_reset();
      step(1'b0);
      step(1'b0);

      // Priority: layer 1 beats layer 3 and background
      set_layer(1, 1'b1, 8'h1C);
      set_layer(3, 1'b1, 8'hE0);
      BGDrawingRequest = 1'b1;
      step(1'b0);
      step(1'b0);
      chk("t1_rgb", RGBOut, 8'h1C);
      chk("t1_top", topLayer, 5'd1);
      clear_layers();
      step(1'b0);
      step(1'b0);
      chk("t1_mif", RGBOut, 8'hA5);
      chk("t1_mif_top", topLayer, 5'd31);

      // Transparency and enable
      set_layer(0, 1'b1, 8'hFF);
      set_layer(2, 1'b1, 8'h03);
      BGDrawingRequest = 1'b1;
      step(1'b0);
      step(1'b0);
      chk("t2_transp", RGBOut, 8'h03);
      layerEnable[2] = 1'b0;
      step(1'b0);
      step(1'b0);
      chk("t2_disable", RGBOut, 8'h55);
      chk("t2_disable_top", topLayer, 5'd31);
      layerEnable = '1;
      clear_layers();
      step(1'b0);

      // Blink: layer 1 visible in frames 0-1, hidden in frames 2-3
      do_reset();
      blinkMask[1] = 1'b1;
      set_layer(1, 1'b1, 8'h1C);
      BGDrawingRequest = 1'b1;
      for (int f = 0; f < 4; f++) begin
         step(1'b0);
         step(1'b0);
         chk("t3_blink", RGBOut, (f < 2) ? 8'h1C : 8'h55);
         step(1'b1);
      end
      for (int f = 0; f < 256; f++) step(1'b1);
      step(1'b0);
      step(1'b0);
      chk("t3_wrap", RGBOut, 8'h1C);
      blinkMask = '0;
      clear_layers();
      step(1'b0);
      step(1'b1);

      // Collision: overlap of layers 0 and 2 once, layer 3 alone elsewhere
      set_layer(0, 1'b1, 8'h10);
      set_layer(2, 1'b1, 8'h22);
      step(1'b0);
      clear_layers();
      set_layer(3, 1'b1, 8'hE0);
      step(1'b0);
      clear_layers();
      step(1'b0);
      step(1'b1);
      chk("t4_valid", collisionValid, 1'b1);
      chk("t4_flags", collisionFlags, 4'b0100);
      step(1'b0);
      chk("t4_valid_low", collisionValid, 1'b0);
      step(1'b0);
      step(1'b1);
      chk("t4_clear", collisionFlags, 4'b0000);

      // Boundary: overlap seen by the accumulator in the startOfFrame cycle
      set_layer(0, 1'b1, 8'h10);
      set_layer(3, 1'b1, 8'hE0);
      step(1'b0);
      clear_layers();
      step(1'b1);
      chk("t5_boundary", collisionFlags, 4'b1000);
      step(1'b1);
      chk("t5_next", collisionFlags, 4'b0000);

      // Reset mid-frame discards the accumulated hit
      set_layer(0, 1'b1, 8'h10);
      set_layer(1, 1'b1, 8'h1C);
      step(1'b0);
      clear_layers();
      step(1'b0);
      do_reset();
      step(1'b0);
      step(1'b1);
      chk("t6_after_rst", collisionFlags, 4'b0000);
      step(1'b0);
      step(1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
